// File: rtl/mips_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: opcodes, datapath select
// codes, ALU operations, FSM states and the decoded instruction class.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE  = 6'b000000;
  localparam logic [5:0] OP_REGIMM = 6'b000001;
  localparam logic [5:0] OP_J      = 6'b000010;
  localparam logic [5:0] OP_JAL    = 6'b000011;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_BNE    = 6'b000101;
  localparam logic [5:0] OP_ADDI   = 6'b001000;
  localparam logic [5:0] OP_ADDIU  = 6'b001001;
  localparam logic [5:0] OP_SLTI   = 6'b001010;
  localparam logic [5:0] OP_SLTIU  = 6'b001011;
  localparam logic [5:0] OP_ANDI   = 6'b001100;
  localparam logic [5:0] OP_ORI    = 6'b001101;
  localparam logic [5:0] OP_XORI   = 6'b001110;
  localparam logic [5:0] OP_LUI    = 6'b001111;
  localparam logic [5:0] OP_LB     = 6'b100000;
  localparam logic [5:0] OP_LH     = 6'b100001;
  localparam logic [5:0] OP_LW     = 6'b100011;
  localparam logic [5:0] OP_LBU    = 6'b100100;
  localparam logic [5:0] OP_LHU    = 6'b100101;
  localparam logic [5:0] OP_SB     = 6'b101000;
  localparam logic [5:0] OP_SH     = 6'b101001;
  localparam logic [5:0] OP_SW     = 6'b101011;

  localparam logic [4:0] RT_BGEZ = 5'b00001;

  // ALU_FUNCT defers to the R-type funct decoder; ALU_PASSA forwards rs for BGEZ.
  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_AND   = 4'd2;
  localparam logic [3:0] ALU_OR    = 4'd3;
  localparam logic [3:0] ALU_XOR   = 4'd4;
  localparam logic [3:0] ALU_SLT   = 4'd5;
  localparam logic [3:0] ALU_SLTU  = 4'd6;
  localparam logic [3:0] ALU_LUI   = 4'd7;
  localparam logic [3:0] ALU_FUNCT = 4'd8;
  localparam logic [3:0] ALU_PASSA = 4'd9;

  localparam logic [1:0] PC_SRC_SEQ    = 2'd0;
  localparam logic [1:0] PC_SRC_BRANCH = 2'd1;
  localparam logic [1:0] PC_SRC_JUMP   = 2'd2;

  localparam logic [1:0] REG_DST_RT = 2'd0;
  localparam logic [1:0] REG_DST_RD = 2'd1;
  localparam logic [1:0] REG_DST_RA = 2'd2;

  localparam logic [1:0] WB_SEL_ALU  = 2'd0;
  localparam logic [1:0] WB_SEL_MEM  = 2'd1;
  localparam logic [1:0] WB_SEL_LINK = 2'd2;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  typedef enum logic [2:0] {
    C_RTYPE, C_IALU, C_LOAD, C_STORE, C_BRANCH, C_JUMP, C_JAL, C_ILLEGAL
  } op_class_t;

  typedef enum logic [1:0] {BR_EQ, BR_NE, BR_GEZ} br_kind_t;

  typedef struct packed {
    op_class_t  cls;
    br_kind_t   br;
    logic [3:0] alu;
  } decode_t;

endpackage

// File: rtl/mips_op_classify.sv
// Combinational opcode/rt classifier: instruction class, branch flavour and ALU op.
module mips_op_classify
  import mips_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [4:0] rt_field,
  output decode_t    dec
);

  always_comb begin
    dec = '{cls: C_ILLEGAL, br: BR_EQ, alu: ALU_ADD};
    case (opcode)
      OP_RTYPE: begin dec.cls = C_RTYPE; dec.alu = ALU_FUNCT; end
      OP_REGIMM: begin
        // Only BGEZ is implemented in the REGIMM group; other rt codes stay illegal.
        if (rt_field == RT_BGEZ) begin
          dec.cls = C_BRANCH; dec.br = BR_GEZ; dec.alu = ALU_PASSA;
        end
      end
      OP_J:     dec.cls = C_JUMP;
      OP_JAL:   dec.cls = C_JAL;
      OP_BEQ:   begin dec.cls = C_BRANCH; dec.br = BR_EQ; dec.alu = ALU_SUB; end
      OP_BNE:   begin dec.cls = C_BRANCH; dec.br = BR_NE; dec.alu = ALU_SUB; end
      OP_ADDI, OP_ADDIU: dec.cls = C_IALU;
      OP_SLTI:  begin dec.cls = C_IALU; dec.alu = ALU_SLT;  end
      OP_SLTIU: begin dec.cls = C_IALU; dec.alu = ALU_SLTU; end
      OP_ANDI:  begin dec.cls = C_IALU; dec.alu = ALU_AND;  end
      OP_ORI:   begin dec.cls = C_IALU; dec.alu = ALU_OR;   end
      OP_XORI:  begin dec.cls = C_IALU; dec.alu = ALU_XOR;  end
      OP_LUI:   begin dec.cls = C_IALU; dec.alu = ALU_LUI;  end
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: dec.cls = C_LOAD;
      OP_SB, OP_SH, OP_SW: dec.cls = C_STORE;
      default: ;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS sequencer: FETCH/DECODE/EXEC/MEM/WB with a req/ready memory port,
// sticky illegal-opcode and bus-timeout flags. The FSM state is exported for observation.
module mips_multicycle_ctrl
  import mips_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 255,
  parameter int unsigned WAIT_W   = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [4:0] rt_field,
  input  logic       alu_zero,
  input  logic       alu_neg,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       iord,
  output logic       ir_write,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic       reg_write,
  output logic [1:0] reg_dst,
  output logic [1:0] wb_sel,
  output logic       alu_src,
  output logic [3:0] alu_ctrl,
  output logic       instr_done,
  output logic       illegal_op,
  output logic       bus_error,
  output state_t     state
);

  // Memory handshake: mem_req is raised in FETCH/MEM and held until mem_ready is
  // seen high on a rising edge; that edge completes the transfer. mem_we is
  // meaningful only while mem_req is high.

  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

  state_t            state_q, state_d;
  decode_t           dec, dec_q;
  logic [WAIT_W-1:0] wait_cnt;
  logic              illegal_q, bus_err_q;
  logic              mem_phase, stalled, timeout;

  mips_op_classify u_classify (
    .opcode   (opcode),
    .rt_field (rt_field),
    .dec      (dec)
  );

  assign mem_phase = (state_q == S_FETCH) || (state_q == S_MEM);
  assign stalled   = mem_phase && !mem_ready;
  // The stall that would push the counter to MAX_WAIT is the one that times out.
  assign timeout   = stalled && (wait_cnt == WAIT_LAST);
  assign state     = state_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      dec_q     <= '0;
      wait_cnt  <= '0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      wait_cnt <= stalled ? wait_cnt + 1'b1 : '0;
      if (state_q == S_DECODE) dec_q <= dec;
      if (state_q == S_DECODE && dec.cls == C_ILLEGAL) illegal_q <= 1'b1;
      if (timeout) bus_err_q <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (timeout) state_d = S_HALT;
                else if (mem_ready) state_d = S_DECODE;
      S_DECODE: state_d = (dec.cls == C_ILLEGAL) ? S_HALT : S_EXEC;
      S_EXEC: begin
        case (dec_q.cls)
          C_RTYPE, C_IALU, C_JAL: state_d = S_WB;
          C_LOAD, C_STORE:        state_d = S_MEM;
          default:                state_d = S_FETCH;
        endcase
      end
      S_MEM:    if (timeout) state_d = S_HALT;
                else if (mem_ready) state_d = (dec_q.cls == C_LOAD) ? S_WB : S_FETCH;
      S_WB:     state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_FETCH;
    endcase
  end

  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = PC_SRC_SEQ;
    reg_write  = 1'b0;
    reg_dst    = REG_DST_RT;
    wb_sel     = WB_SEL_ALU;
    alu_src    = 1'b0;
    alu_ctrl   = ALU_ADD;
    instr_done = 1'b0;
    illegal_op = illegal_q && !reset;
    bus_error  = (bus_err_q || timeout) && !reset;
    if (!reset) begin
      case (state_q)
        S_FETCH: begin
          mem_req = 1'b1;
          if (mem_ready) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
          end
        end
        S_EXEC: begin
          alu_src  = (dec_q.cls == C_IALU) || (dec_q.cls == C_LOAD) || (dec_q.cls == C_STORE);
          alu_ctrl = dec_q.alu;
          case (dec_q.cls)
            C_BRANCH: begin
              pc_src     = PC_SRC_BRANCH;
              instr_done = 1'b1;
              case (dec_q.br)
                BR_EQ:   pc_write = alu_zero;
                BR_NE:   pc_write = !alu_zero;
                default: pc_write = !alu_neg;
              endcase
            end
            C_JUMP: begin
              pc_write = 1'b1; pc_src = PC_SRC_JUMP; instr_done = 1'b1;
            end
            C_JAL: begin
              pc_write = 1'b1; pc_src = PC_SRC_JUMP;
            end
            default: ;
          endcase
        end
        S_MEM: begin
          mem_req    = 1'b1;
          iord       = 1'b1;
          mem_we     = (dec_q.cls == C_STORE);
          alu_src    = 1'b1;
          instr_done = mem_ready && (dec_q.cls == C_STORE);
        end
        S_WB: begin
          reg_write  = 1'b1;
          instr_done = 1'b1;
          case (dec_q.cls)
            C_RTYPE: reg_dst = REG_DST_RD;
            C_LOAD:  wb_sel  = WB_SEL_MEM;
            C_JAL:   begin reg_dst = REG_DST_RA; wb_sel = WB_SEL_LINK; end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl: per-scenario tasks with hand-computed
// per-cycle control vectors, instantiated with a short MAX_WAIT of 4.
module tb_mips_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] opcode = '0;
  logic [4:0] rt_field = '0;
  logic       alu_zero = 1'b0;
  logic       alu_neg = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_req, mem_we, iord, ir_write, pc_write, reg_write, alu_src, instr_done;
  logic       illegal_op, bus_error;
  logic [1:0] pc_src, reg_dst, wb_sel;
  logic [3:0] alu_ctrl;
  logic [2:0] dbg_state;

  int vec_cnt = 0;
  int err_cnt = 0;

  logic [17:0] exp_q[$];
  logic [5:0]  op_q[$];
  logic        rdy_q[$];

  logic [17:0] ctl;
  assign ctl = {mem_req, mem_we, iord, ir_write, pc_write, pc_src, reg_write,
                reg_dst, wb_sel, alu_src, alu_ctrl, instr_done};

  always #5 clk = ~clk;

  mips_multicycle_ctrl #(.MAX_WAIT(4), .WAIT_W(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .opcode     (opcode),
    .rt_field   (rt_field),
    .alu_zero   (alu_zero),
    .alu_neg    (alu_neg),
    .mem_ready  (mem_ready),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .iord       (iord),
    .ir_write   (ir_write),
    .pc_write   (pc_write),
    .pc_src     (pc_src),
    .reg_write  (reg_write),
    .reg_dst    (reg_dst),
    .wb_sel     (wb_sel),
    .alu_src    (alu_src),
    .alu_ctrl   (alu_ctrl),
    .instr_done (instr_done),
    .illegal_op (illegal_op),
    .bus_error  (bus_error),
    .state      (dbg_state)
  );

  // Field order: req, we, iord, ir_write, pc_write, pc_src, reg_write, reg_dst, wb_sel, alu_src, alu_ctrl, done
  function automatic logic [17:0] mk(input int req, input int we, input int io, input int irw,
                                     input int pcw, input int pcs, input int rw, input int rd,
                                     input int wb, input int as, input int alu, input int dn);
    return {1'(req), 1'(we), 1'(io), 1'(irw), 1'(pcw), 2'(pcs), 1'(rw), 2'(rd), 2'(wb),
            1'(as), 4'(alu), 1'(dn)};
  endfunction

  task automatic push(input logic [5:0] op, input logic rdy, input logic [17:0] e);
    op_q.push_back(op);
    rdy_q.push_back(rdy);
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    @(negedge clk);
    vec_cnt++; if (ctl !== 18'd0) begin err_cnt++; $display("FAIL reset_ctl got %h want %h", ctl, 18'd0); end
    vec_cnt++; if (illegal_op !== 1'b0) begin err_cnt++; $display("FAIL reset_illegal got %b want 0", illegal_op); end
    vec_cnt++; if (bus_error !== 1'b0) begin err_cnt++; $display("FAIL reset_bus_error got %b want 0", bus_error); end
    vec_cnt++; if (dbg_state !== 3'd0) begin err_cnt++; $display("FAIL reset_state got %0d want 0", dbg_state); end
  endtask

  task automatic test_addi();
    logic [17:0] e;
    int n = 1;
    do_reset();
    push(6'h08, 1'b1, mk(1,0,0,1,1,0,0,0,0,0,0,0));
    push(6'h08, 1'b1, mk(0,0,0,0,0,0,0,0,0,0,0,0));
    push(6'h08, 1'b1, mk(0,0,0,0,0,0,0,0,0,1,0,0));
    push(6'h08, 1'b1, mk(0,0,0,0,0,0,1,0,0,0,0,1));
    push(6'h08, 1'b1, mk(1,0,0,1,1,0,0,0,0,0,0,0));
    while (exp_q.size() != 0) begin
      opcode = op_q.pop_front(); mem_ready = rdy_q.pop_front(); e = exp_q.pop_front();
      @(negedge clk);
      vec_cnt++;
      if (ctl !== e) begin err_cnt++; $display("FAIL addi cycle %0d ctl got %h want %h", n, ctl, e); end
      n++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_lw();
    logic [17:0] e;
    int n = 1;
    do_reset();
    push(6'h23, 1'b1, mk(1,0,0,1,1,0,0,0,0,0,0,0));
    push(6'h23, 1'b0, mk(0,0,0,0,0,0,0,0,0,0,0,0));
    push(6'h23, 1'b0, mk(0,0,0,0,0,0,0,0,0,1,0,0));
    for (int i = 0; i < 3; i++) push(6'h23, 1'b0, mk(1,0,1,0,0,0,0,0,0,1,0,0));
    push(6'h23, 1'b1, mk(1,0,1,0,0,0,0,0,0,1,0,0));
    push(6'h23, 1'b0, mk(0,0,0,0,0,0,1,0,1,0,0,1));
    while (exp_q.size() != 0) begin
      opcode = op_q.pop_front(); mem_ready = rdy_q.pop_front(); e = exp_q.pop_front();
      @(negedge clk);
      vec_cnt++;
      if (ctl !== e) begin err_cnt++; $display("FAIL lw cycle %0d ctl got %h want %h", n, ctl, e); end
      n++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_branch();
    logic [17:0] e, f;
    int n = 1;
    f = mk(1,0,0,1,1,0,0,0,0,0,0,0);
    do_reset();
    alu_zero = 1'b1; alu_neg = 1'b0; rt_field = 5'd1;
    push(6'h04, 1'b1, f); push(6'h04, 1'b1, 18'd0);
    push(6'h04, 1'b1, mk(0,0,0,0,1,1,0,0,0,0,1,1));
    push(6'h05, 1'b1, f); push(6'h05, 1'b1, 18'd0);
    push(6'h05, 1'b1, mk(0,0,0,0,0,1,0,0,0,0,1,1));
    push(6'h01, 1'b1, f); push(6'h01, 1'b1, 18'd0);
    push(6'h01, 1'b1, mk(0,0,0,0,1,1,0,0,0,0,9,1));
    while (exp_q.size() != 0) begin
      opcode = op_q.pop_front(); mem_ready = rdy_q.pop_front(); e = exp_q.pop_front();
      @(negedge clk);
      vec_cnt++;
      if (ctl !== e) begin err_cnt++; $display("FAIL branch cycle %0d ctl got %h want %h", n, ctl, e); end
      n++;
      @(posedge clk); #1;
    end
    alu_zero = 1'b0; rt_field = 5'd0;
  endtask

  task automatic test_jump();
    logic [17:0] e, f;
    int n = 1;
    f = mk(1,0,0,1,1,0,0,0,0,0,0,0);
    do_reset();
    push(6'h02, 1'b1, f); push(6'h02, 1'b1, 18'd0);
    push(6'h02, 1'b1, mk(0,0,0,0,1,2,0,0,0,0,0,1));
    push(6'h03, 1'b1, f); push(6'h03, 1'b1, 18'd0);
    push(6'h03, 1'b1, mk(0,0,0,0,1,2,0,0,0,0,0,0));
    push(6'h03, 1'b1, mk(0,0,0,0,0,0,1,2,2,0,0,1));
    push(6'h08, 1'b1, f);
    while (exp_q.size() != 0) begin
      opcode = op_q.pop_front(); mem_ready = rdy_q.pop_front(); e = exp_q.pop_front();
      @(negedge clk);
      vec_cnt++;
      if (ctl !== e) begin err_cnt++; $display("FAIL jump cycle %0d ctl got %h want %h", n, ctl, e); end
      n++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    logic [17:0] e, f;
    int n = 1;
    f = mk(1,0,0,1,1,0,0,0,0,0,0,0);
    do_reset();
    push(6'h00, 1'b1, f); push(6'h00, 1'b1, 18'd0);
    push(6'h00, 1'b1, mk(0,0,0,0,0,0,0,0,0,0,8,0));
    push(6'h00, 1'b1, mk(0,0,0,0,0,0,1,1,0,0,0,1));
    push(6'h2B, 1'b1, f); push(6'h2B, 1'b1, 18'd0);
    push(6'h2B, 1'b1, mk(0,0,0,0,0,0,0,0,0,1,0,0));
    push(6'h2B, 1'b1, mk(1,1,1,0,0,0,0,0,0,1,0,1));
    push(6'h0D, 1'b1, f); push(6'h0D, 1'b1, 18'd0);
    push(6'h0D, 1'b1, mk(0,0,0,0,0,0,0,0,0,1,3,0));
    push(6'h0D, 1'b1, mk(0,0,0,0,0,0,1,0,0,0,0,1));
    while (exp_q.size() != 0) begin
      opcode = op_q.pop_front(); mem_ready = rdy_q.pop_front(); e = exp_q.pop_front();
      @(negedge clk);
      vec_cnt++;
      if (ctl !== e) begin err_cnt++; $display("FAIL b2b cycle %0d ctl got %h want %h", n, ctl, e); end
      n++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_illegal();
    logic [17:0] e, f;
    int n = 1;
    f = mk(1,0,0,1,1,0,0,0,0,0,0,0);
    do_reset();
    rt_field = 5'd0;
    push(6'h3F, 1'b1, f);
    for (int i = 0; i < 4; i++) push(6'h3F, 1'b1, 18'd0);
    while (exp_q.size() != 0) begin
      opcode = op_q.pop_front(); mem_ready = rdy_q.pop_front(); e = exp_q.pop_front();
      @(negedge clk);
      vec_cnt++;
      if (ctl !== e) begin err_cnt++; $display("FAIL illegal cycle %0d ctl got %h want %h", n, ctl, e); end
      n++;
      @(posedge clk); #1;
    end
    @(negedge clk);
    vec_cnt++; if (illegal_op !== 1'b1) begin err_cnt++; $display("FAIL illegal_flag got %b want 1", illegal_op); end
    vec_cnt++; if (dbg_state !== 3'd5) begin err_cnt++; $display("FAIL illegal_halt got %0d want 5", dbg_state); end
    reset = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    vec_cnt++; if (illegal_op !== 1'b0) begin err_cnt++; $display("FAIL illegal_clear got %b want 0", illegal_op); end
    @(posedge clk); #1;
    reset = 1'b0; rt_field = 5'd2;
    push(6'h01, 1'b1, f); push(6'h01, 1'b1, 18'd0); push(6'h01, 1'b1, 18'd0);
    while (exp_q.size() != 0) begin
      opcode = op_q.pop_front(); mem_ready = rdy_q.pop_front(); e = exp_q.pop_front();
      @(negedge clk);
      vec_cnt++;
      if (ctl !== e) begin err_cnt++; $display("FAIL regimm cycle %0d ctl got %h want %h", n, ctl, e); end
      n++;
      @(posedge clk); #1;
    end
    @(negedge clk);
    vec_cnt++; if (illegal_op !== 1'b1) begin err_cnt++; $display("FAIL regimm_flag got %b want 1", illegal_op); end
    reset = 1'b1; rt_field = 5'd0;
    @(posedge clk); #1;
    reset = 1'b0; opcode = 6'h08; mem_ready = 1'b1;
    @(negedge clk);
    vec_cnt++; if (ctl !== f) begin err_cnt++; $display("FAIL resume_ctl got %h want %h", ctl, f); end
    vec_cnt++; if (dbg_state !== 3'd0) begin err_cnt++; $display("FAIL resume_state got %0d want 0", dbg_state); end
    vec_cnt++; if (illegal_op !== 1'b0) begin err_cnt++; $display("FAIL resume_flag got %b want 0", illegal_op); end
    @(posedge clk); #1;
  endtask

  task automatic test_timeout();
    do_reset();
    opcode = 6'h00; mem_ready = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      if (i == 5) mem_ready = 1'b1;
      @(negedge clk);
      vec_cnt++;
      if (mem_req !== (i <= 4)) begin err_cnt++; $display("FAIL timeout_req cycle %0d got %b want %b", i, mem_req, (i <= 4)); end
      vec_cnt++;
      if (bus_error !== (i >= 4)) begin err_cnt++; $display("FAIL timeout_flag cycle %0d got %b want %b", i, bus_error, (i >= 4)); end
      @(posedge clk); #1;
    end
    @(negedge clk);
    vec_cnt++; if (dbg_state !== 3'd5) begin err_cnt++; $display("FAIL timeout_halt got %0d want 5", dbg_state); end
    mem_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [17:0] e, f, m;
    int n = 1;
    f = mk(1,0,0,1,1,0,0,0,0,0,0,0);
    m = mk(1,1,1,0,0,0,0,0,0,1,0,0);
    do_reset();
    push(6'h2B, 1'b1, f); push(6'h2B, 1'b0, 18'd0);
    push(6'h2B, 1'b0, mk(0,0,0,0,0,0,0,0,0,1,0,0));
    push(6'h2B, 1'b0, m);
    while (exp_q.size() != 0) begin
      opcode = op_q.pop_front(); mem_ready = rdy_q.pop_front(); e = exp_q.pop_front();
      @(negedge clk);
      vec_cnt++;
      if (ctl !== e) begin err_cnt++; $display("FAIL sw_wait cycle %0d ctl got %h want %h", n, ctl, e); end
      n++;
      @(posedge clk); #1;
    end
    @(negedge clk);
    vec_cnt++; if (ctl !== m) begin err_cnt++; $display("FAIL sw_wait2 ctl got %h want %h", ctl, m); end
    reset = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    vec_cnt++; if (dbg_state !== 3'd0) begin err_cnt++; $display("FAIL midrst_state got %0d want 0", dbg_state); end
    vec_cnt++; if (mem_req !== 1'b0) begin err_cnt++; $display("FAIL midrst_req got %b want 0", mem_req); end
    vec_cnt++; if (mem_we !== 1'b0) begin err_cnt++; $display("FAIL midrst_we got %b want 0", mem_we); end
    @(posedge clk); #1;
    reset = 1'b0; opcode = 6'h08; mem_ready = 1'b1;
    @(negedge clk);
    vec_cnt++; if (ctl !== f) begin err_cnt++; $display("FAIL midrst_fetch got %h want %h", ctl, f); end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_addi();
    test_lw();
    test_branch();
    test_jump();
    test_back_to_back();
    test_illegal();
    test_timeout();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
Multi-cycle sequencer for the MIPS datapath. Steps each instruction through FETCH/DECODE/EXEC/MEM/WB and drives the datapath enables (PC, IR, register file, ALU, memory port) with a req/ready handshake to a single shared instruction/data memory. It replaces the single-cycle opcode decode with per-state control. It also flags illegal opcodes and memory timeouts.

Parameters:
MAX_WAIT, 255, cycles to wait for mem_ready before a bus error (1..65535).
WAIT_W, 16, width of the wait counter; must hold MAX_WAIT.

Ports:
clk  input  1  system clock; everything updates on the rising edge.
reset  input  1  synchronous, active-high reset.
opcode  input  6  IR[31:26], valid from DECODE onward.
rt_field  input  5  IR[20:16]; selects BGEZ (rt=00001) under REGIMM.
alu_zero  input  1  ALU result == 0.
alu_neg  input  1  ALU result sign bit.
mem_ready  input  1  memory accepted or completed the current request.
mem_req  output  1  memory request; held until mem_ready.
mem_we  output  1  write request; valid only while mem_req is high.
iord  output  1  0 selects PC as the memory address, 1 selects the ALU result.
ir_write  output  1  latch fetched word into IR.
pc_write  output  1  update PC.
pc_src  output  2  0 = PC+4, 1 = branch target, 2 = jump target.
reg_write  output  1  register file write enable.
reg_dst  output  2  0 = rt, 1 = rd, 2 = r31.
wb_sel  output  2  0 = ALU, 1 = memory data, 2 = PC+4.
alu_src  output  1  0 = register operand, 1 = immediate.
alu_ctrl  output  4  ALU operation code (shared package encoding).
instr_done  output  1  one-cycle pulse on the final cycle of each instruction.
illegal_op  output  1  sticky; set on an undecodable opcode.
bus_error  output  1  sticky; set on a memory timeout.

Behaviour:
- States: FETCH, DECODE, EXEC, MEM, WB, HALT.
- Reset: next state is FETCH. All outputs are 0, including the sticky flags and the wait counter.
- Reset mid-operation wins over everything: mem_req drops on the following cycle and any pending write is abandoned.
- FETCH: mem_req=1, iord=0, mem_we=0.
  - On mem_ready: ir_write=1, pc_write=1, pc_src=0, go to DECODE.
  - Otherwise stay in FETCH.
- DECODE: classify opcode.
  - Undecodable opcode (including REGIMM with rt≠1): set illegal_op, go to HALT.
  - Otherwise go to EXEC.
- EXEC by class:
  - R-type: alu_src=0 → WB, reg_dst=1.
  - I-ALU (ADDI/ADDIU/SLTI/SLTIU/ANDI/ORI/XORI/LUI): alu_src=1 → WB, reg_dst=0.
  - Load/store: alu_src=1, alu_ctrl=ADD (address) → MEM.
  - BEQ: pc_write=alu_zero, pc_src=1, done.
  - BNE: pc_write=!alu_zero, pc_src=1, done.
  - BGEZ: pc_write=!alu_neg, pc_src=1, done.
  - J: pc_write=1, pc_src=2, done.
  - JAL: pc_write=1, pc_src=2 → WB, reg_dst=2, wb_sel=2.
- MEM: mem_req=1, iord=1, mem_we=1 for SB/SH/SW.
  - On mem_ready: a load goes to WB with wb_sel=1; a store is done.
- WB: reg_write=1 for exactly one cycle, done.
- "done": instr_done=1 this cycle, next state FETCH.
- Latency with mem_ready asserted in the same cycle as the request:
  - branch/J: 3 cycles
  - R/I-ALU/JAL/store: 4 cycles
  - load: 5 cycles
- Wait counter:
  - Clears on entry to FETCH or MEM.
  - Increments each cycle mem_req=1 && !mem_ready.
  - When it reaches MAX_WAIT: set bus_error, drop mem_req, go to HALT.
  - A mem_ready arriving in that same cycle is ignored.
- HALT: all enables 0 and mem_req=0. Only reset exits HALT.
- Moore outputs from state and registered opcode class. EXEC branch enables additionally depend on the alu_zero/alu_neg inputs in the same cycle.
- pc_write and reg_write are never both high except in JAL EXEC (pc only) followed by WB (reg only).

Decomposition:
- Shared package mips_pkg holds:
  - opcode localparams (R 000000, REGIMM 000001, J 000010, JAL 000011, BEQ 000100, BNE 000101, ADDI–LUI 001000–001111, LB 100000, LH 100001, LW 100011, LBU 100100, LHU 100101, SB 101000, SH 101001, SW 101011)
  - ALU control encodings
  - pc_src, reg_dst and wb_sel encodings
  - state enum
- One sub-module: mips_op_classify, a combinational map from opcode/rt to class (RTYPE, IALU, LOAD, STORE, BRANCH, JUMP, JAL, ILLEGAL) plus alu_ctrl.

Test Plan:
- ADDI, ready always 1 → pulses in order ir_write, (DECODE), alu_src=1, reg_write + instr_done; total 4 cycles.
- LW, ready delayed 3 cycles in MEM → mem_req stays high with iord=1 for 4 cycles, then WB with wb_sel=1; instr_done at cycle 8.
- BEQ with alu_zero=1, then BNE with alu_zero=1 → pc_write=1/pc_src=1 for the first, pc_write=0 for the second; each takes 3 cycles.
- Opcode 111111 → illegal_op=1, HALT; no further mem_req until reset; reset clears the flag and FETCH resumes.
- MAX_WAIT=4, mem_ready held 0 in FETCH → bus_error on cycle 4, mem_req=0 the next cycle.
- Reset asserted during the SW MEM wait → mem_req=0 and mem_we=0 the cycle after the edge; state is FETCH.
